// File: rtl/ex_mem_stage_pkg.sv
// Shared types for the EX/MEM stage: word/register types, FSM state and small helpers.
package ex_mem_stage_pkg;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned REG_BITS  = 5;

    typedef logic [WORD_BITS-1:0] word_t;
    typedef logic [REG_BITS-1:0]  regbits_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } exmem_state_t;

    function automatic logic is_mem_op(input logic rd, input logic wr);
        return rd | wr;
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Data-memory request bus between the EX/MEM stage (master) and the dcache (slave).
interface ex_mem_stage_if #(
    parameter int unsigned WORD_W = 32
);
    logic              dmemREN;
    logic              dmemWEN;
    logic [WORD_W-1:0] dmemaddr;
    logic [WORD_W-1:0] dmemstore;
    logic              dhit;
    logic [WORD_W-1:0] dmemload;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload
    );
endinterface

// File: rtl/ex_mem_stage_llsc.sv
// LL/SC link register: set by a completed LL, cleared by a matching own store or snoop.
module llsc_link #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              set,
    input  logic [WORD_W-1:0] set_addr,
    input  logic              wr_done,
    input  logic [WORD_W-1:0] wr_addr,
    input  logic              snoop,
    input  logic [WORD_W-1:0] snoop_addr,
    input  logic [WORD_W-1:0] chk_addr,
    output logic              match
);
    logic              link_valid;
    logic [WORD_W-1:0] link_addr;
    logic              clr;

    assign clr = (wr_done && (wr_addr == link_addr)) ||
                 (snoop && (snoop_addr == link_addr));

    // A snoop landing on the same edge as the SC check already kills the link.
    assign match = link_valid && (chk_addr == link_addr) &&
                   !(snoop && (snoop_addr == link_addr));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (set) begin
            link_valid <= 1'b1;
            link_addr  <= set_addr;
        end else if (clr) begin
            link_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline latch plus data-memory request engine with LL/SC support.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned REG_W  = 5
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              freeze,
    input  logic              regWr_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic              datomic_i,
    input  logic              halt_i,
    input  logic              mem_to_reg_i,
    input  logic [WORD_W-1:0] alu_out_i,
    input  logic [WORD_W-1:0] store_i,
    input  logic [REG_W-1:0]  wsel_i,
    input  logic [WORD_W-1:0] pc_p4_i,
    input  logic [WORD_W-1:0] up_imm_i,
    input  logic [WORD_W-1:0] instr_i,
    input  logic              ccinv,
    input  logic [WORD_W-1:0] ccsnoopaddr,
    output logic              regWr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              datomic_o,
    output logic              halt_o,
    output logic              mem_to_reg_o,
    output logic [WORD_W-1:0] alu_out_o,
    output logic [WORD_W-1:0] store_o,
    output logic [REG_W-1:0]  wsel_o,
    output logic [WORD_W-1:0] pc_p4_o,
    output logic [WORD_W-1:0] up_imm_o,
    output logic [WORD_W-1:0] instr_o,
    output logic [WORD_W-1:0] load_o,
    output logic              mem_stall_o,
    ex_mem_stage_if.master    dmem
);
    exmem_state_t state, state_n;
    logic         sc_fail;
    logic         load_en, bubble, complete, ren, wen, sc_match;

    always_comb begin
        state_n  = state;
        load_en  = 1'b0;
        bubble   = 1'b0;
        complete = 1'b0;
        ren      = 1'b0;
        wen      = 1'b0;
        case (state)
            REQ: begin
                ren      = mem_read_o;
                wen      = mem_write_o & ~sc_fail;
                // A failed SC never issues, so it retires without waiting for dhit.
                complete = dmem.dhit | sc_fail;
                if (complete) state_n = DONE;
            end
            default: begin
                if (flush) begin
                    bubble  = 1'b1;
                    state_n = IDLE;
                end else if (!freeze && en) begin
                    load_en = 1'b1;
                    state_n = is_mem_op(mem_read_i, mem_write_i) ? REQ : IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            regWr_o      <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            datomic_o    <= 1'b0;
            halt_o       <= 1'b0;
            mem_to_reg_o <= 1'b0;
            alu_out_o    <= '0;
            store_o      <= '0;
            wsel_o       <= '0;
            pc_p4_o      <= '0;
            up_imm_o     <= '0;
            instr_o      <= '0;
            sc_fail      <= 1'b0;
            load_o       <= '0;
        end else begin
            if (bubble) begin
                regWr_o      <= 1'b0;
                mem_read_o   <= 1'b0;
                mem_write_o  <= 1'b0;
                datomic_o    <= 1'b0;
                halt_o       <= 1'b0;
                mem_to_reg_o <= 1'b0;
                alu_out_o    <= '0;
                store_o      <= '0;
                wsel_o       <= '0;
                pc_p4_o      <= '0;
                up_imm_o     <= '0;
                instr_o      <= '0;
                sc_fail      <= 1'b0;
                load_o       <= '0;
            end else if (load_en) begin
                regWr_o      <= regWr_i;
                mem_read_o   <= mem_read_i;
                mem_write_o  <= mem_write_i;
                datomic_o    <= datomic_i;
                halt_o       <= halt_i;
                // SC writes its success flag back, so route it through the load path.
                mem_to_reg_o <= mem_to_reg_i | (datomic_i & mem_write_i);
                alu_out_o    <= alu_out_i;
                store_o      <= store_i;
                wsel_o       <= wsel_i;
                pc_p4_o      <= pc_p4_i;
                up_imm_o     <= up_imm_i;
                instr_o      <= instr_i;
                sc_fail      <= datomic_i & mem_write_i & ~sc_match;
            end
            if (complete) begin
                if (datomic_o && mem_write_o)
                    load_o <= {{(WORD_W-1){1'b0}}, ~sc_fail};
                else if (mem_read_o)
                    load_o <= dmem.dmemload;
            end
        end
    end

    llsc_link #(.WORD_W(WORD_W)) u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set        (complete & datomic_o & mem_read_o),
        .set_addr   (alu_out_o),
        .wr_done    (complete & mem_write_o & ~sc_fail),
        .wr_addr    (alu_out_o),
        .snoop      (ccinv),
        .snoop_addr (ccsnoopaddr),
        .chk_addr   (alu_out_i),
        .match      (sc_match)
    );

    assign dmem.dmemREN   = ren;
    assign dmem.dmemWEN   = wen;
    assign dmem.dmemaddr  = alu_out_o;
    assign dmem.dmemstore = store_o;
    assign mem_stall_o    = (state == REQ) & ~dmem.dhit;
endmodule
